// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch port and
// the data port: data has priority, fetch gets a forced win after repeated losses.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_type,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] WAIT_INIT   = 4'(WAIT_CYCLES);
  localparam logic [3:0] STARVE_LIM  = 4'(STARVE_MAX);
  localparam logic [2:0] TYPE_WORD   = 3'b000;

  // owner_q: 1 = fetch port owns the current access, 0 = data port
  logic [1:0]  state_q,      state_d;
  logic [3:0]  wait_cnt_q,   wait_cnt_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        owner_q,      owner_d;
  logic [31:0] addr_q,       addr_d;
  logic        we_q,         we_d;
  logic [2:0]  type_q,       type_d;
  logic [31:0] wdata_q,      wdata_d;
  logic [31:0] if_rdata_q,   if_rdata_d;
  logic [31:0] dm_rdata_q,   dm_rdata_d;

  logic in_idle;
  logic in_access;
  logic in_done;
  logic if_forced;
  logic dm_win;
  logic if_win;

  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    in_access = (state_q == ST_ACCESS);
    in_done   = (state_q == ST_DONE);
    // A starved fetch overrides data priority only when it is actually contending.
    if_forced = (starve_cnt_q == STARVE_LIM);
    dm_win    = in_idle && dm_req && !(if_req && if_forced);
    if_win    = in_idle && if_req && !dm_win;
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    type_d       = type_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (dm_win) begin
          owner_d    = 1'b0;
          addr_d     = dm_addr;
          we_d       = dm_we;
          type_d     = dm_type;
          wdata_d    = dm_wdata;
          wait_cnt_d = WAIT_INIT;
          state_d    = ST_ACCESS;
        end else if (if_win) begin
          owner_d    = 1'b1;
          addr_d     = if_addr;
          we_d       = 1'b0;
          type_d     = TYPE_WORD;
          wdata_d    = 32'd0;
          wait_cnt_d = WAIT_INIT;
          state_d    = ST_ACCESS;
        end

        if (if_win) begin
          starve_cnt_d = 4'd0;
        end else if (dm_win && if_req) begin
          starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end else if (!if_req) begin
          starve_cnt_d = 4'd0;
        end
      end

      ST_ACCESS: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          // Last access cycle: memory data is valid now; stores leave rdata alone.
          if (owner_q) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 4'd0;
      starve_cnt_q <= 4'd0;
      owner_q      <= 1'b0;
      addr_q       <= 32'd0;
      we_q         <= 1'b0;
      type_q       <= 3'd0;
      wdata_q      <= 32'd0;
      if_rdata_q   <= 32'd0;
      dm_rdata_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      type_q       <= type_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // Grants are gated by rstn so nothing is offered in a cycle that is being reset.
  assign if_gnt    = rstn && if_win;
  assign dm_gnt    = rstn && dm_win;
  assign if_valid  = in_done && owner_q;
  assign dm_valid  = in_done && !owner_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = in_access;
  assign mem_we    = in_access && we_q;
  assign mem_type  = in_access ? type_q  : 3'd0;
  assign mem_addr  = in_access ? addr_q  : 32'd0;
  assign mem_wdata = in_access ? wdata_q : 32'd0;
  assign busy      = !in_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (2 and 0 wait states) against a
// transaction-timestamp reference model, directed scenarios then random traffic.
module tb_mem_port_arbiter;

  localparam int W_A = 2;
  localparam int W_B = 0;
  localparam int SM  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn      [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_valid  [2];
  logic [31:0] if_rdata  [2];
  logic        dm_req    [2];
  logic        dm_we     [2];
  logic [2:0]  dm_type   [2];
  logic [31:0] dm_addr   [2];
  logic [31:0] dm_wdata  [2];
  logic        dm_gnt    [2];
  logic        dm_valid  [2];
  logic [31:0] dm_rdata  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [2:0]  mem_type  [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  mem_port_arbiter #(.WAIT_CYCLES(W_A), .STARVE_MAX(SM)) dut_a (
    .clk(clk), .rstn(rstn[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_type(dm_type[0]),
    .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]), .dm_gnt(dm_gnt[0]),
    .dm_valid(dm_valid[0]), .dm_rdata(dm_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_type(mem_type[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0])
  );

  mem_port_arbiter #(.WAIT_CYCLES(W_B), .STARVE_MAX(SM)) dut_b (
    .clk(clk), .rstn(rstn[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_type(dm_type[1]),
    .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]), .dm_gnt(dm_gnt[1]),
    .dm_valid(dm_valid[1]), .dm_rdata(dm_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_type(mem_type[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1])
  );

  // Memories: 1 KiB each, word[i] = 0x1000_0000 + i, written on every enabled store cycle.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  logic        preloaded = 1'b0;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 32'h1000_0000 + 32'(i);
        mem1[i] <= 32'h1000_0000 + 32'(i);
      end
      preloaded <= 1'b1;
    end else begin
      if (mem_en[0] && mem_we[0]) mem0[mem_addr[0][9:2]] <= mem_wdata[0];
      if (mem_en[1] && mem_we[1]) mem1[mem_addr[1][9:2]] <= mem_wdata[1];
    end
  end

  assign mem_rdata[0] = mem0[mem_addr[0][9:2]];
  assign mem_rdata[1] = mem1[mem_addr[1][9:2]];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one outstanding transaction per instance, timed from its grant cycle.
  int          cyc = 0;
  bit          act     [2];
  int          gcyc    [2];
  int          starve  [2];
  bit          t_if    [2];
  bit          t_we    [2];
  logic [2:0]  t_type  [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [31:0] m_if_rd [2];
  logic [31:0] m_dm_rd [2];
  logic [31:0] ref_mem [2][256];

  bit s_if_gnt [2];
  bit s_dm_gnt [2];
  bit s_if_val [2];
  bit s_dm_val [2];
  bit s_rst    [2];
  int rq_if    [2];
  int rq_dm    [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input int k);
    return (k == 0) ? W_A : W_B;
  endfunction

  task automatic model_check(input int k);
    int    w;
    bit    idle, done, access, last, win_dm, win_if;
    int    idx;
    string p;
    w = wait_of(k);
    p = (k == 0) ? "a_" : "b_";
    s_if_gnt[k] = if_gnt[k];
    s_dm_gnt[k] = dm_gnt[k];
    s_if_val[k] = if_valid[k];
    s_dm_val[k] = dm_valid[k];
    s_rst[k]    = !rstn[k];
    if (!rstn[k]) begin
      act[k] = 0; starve[k] = 0; m_if_rd[k] = '0; m_dm_rd[k] = '0;
      return;
    end
    idle   = !act[k];
    done   = act[k] && (cyc == gcyc[k] + 2 + w);
    access = act[k] && !done;
    last   = access && (cyc == gcyc[k] + 1 + w);
    win_dm = idle && dm_req[k] && !(if_req[k] && starve[k] == SM);
    win_if = idle && if_req[k] && !win_dm;

    chk({p, "if_gnt"},   if_gnt[k],   win_if);
    chk({p, "dm_gnt"},   dm_gnt[k],   win_dm);
    chk({p, "busy"},     busy[k],     act[k]);
    chk({p, "mem_en"},   mem_en[k],   access);
    chk({p, "mem_we"},   mem_we[k],   access && t_we[k]);
    chk({p, "if_valid"}, if_valid[k], done && t_if[k]);
    chk({p, "dm_valid"}, dm_valid[k], done && !t_if[k]);
    chk({p, "if_rdata"}, if_rdata[k], m_if_rd[k]);
    chk({p, "dm_rdata"}, dm_rdata[k], m_dm_rd[k]);
    if (access) begin
      chk({p, "mem_addr"}, mem_addr[k], t_addr[k]);
      chk({p, "mem_type"}, 32'(mem_type[k]), 32'(t_type[k]));
      if (t_we[k]) chk({p, "mem_wdata"}, mem_wdata[k], t_wdata[k]);
    end

    if (win_dm || win_if) begin
      act[k]     = 1;
      gcyc[k]    = cyc;
      t_if[k]    = win_if;
      t_we[k]    = win_dm ? dm_we[k] : 1'b0;
      t_type[k]  = win_dm ? dm_type[k] : 3'b000;
      t_addr[k]  = win_dm ? dm_addr[k] : if_addr[k];
      t_wdata[k] = dm_wdata[k];
    end
    if (idle) begin
      if (win_if) starve[k] = 0;
      else if (win_dm && if_req[k]) starve[k] = (starve[k] < SM) ? starve[k] + 1 : SM;
      else if (!if_req[k]) starve[k] = 0;
    end
    if (last) begin
      idx = int'(t_addr[k][9:2]);
      if (t_we[k]) ref_mem[k][idx] = t_wdata[k];
      else if (t_if[k]) m_if_rd[k] = ref_mem[k][idx];
      else m_dm_rd[k] = ref_mem[k][idx];
    end
    if (done) act[k] = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check(0);
    model_check(1);
  endtask

  task automatic adv();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic tick();
    sample();
    adv();
  endtask

  // Returns positioned just after the sample of the valid cycle (or the last tried cycle).
  task automatic wait_valid(input int k, input bit is_if, input int start, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) adv();
      sample();
      if (is_if ? s_if_val[k] : s_dm_val[k]) begin
        lat = start + i;
        break;
      end
    end
  endtask

  task automatic rand_step(input int k);
    if (s_rst[k] && rq_if[k] == 2) rq_if[k] = 0;
    if (s_rst[k] && rq_dm[k] == 2) rq_dm[k] = 0;
    if (s_if_val[k]) rq_if[k] = 0;
    if (s_dm_val[k]) rq_dm[k] = 0;
    if (rq_if[k] == 1 && s_if_gnt[k] && $urandom_range(0, 3) == 0) rq_if[k] = 2;
    if (rq_dm[k] == 1 && s_dm_gnt[k] && $urandom_range(0, 3) == 0) rq_dm[k] = 2;
    if (rq_if[k] == 0 && $urandom_range(0, 2) == 0) begin
      rq_if[k]   = 1;
      if_addr[k] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    end
    if (rq_dm[k] == 0 && $urandom_range(0, 2) == 0) begin
      rq_dm[k]    = 1;
      dm_addr[k]  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      dm_we[k]    = 1'($urandom_range(0, 1));
      dm_type[k]  = 3'($urandom_range(0, 7));
      dm_wdata[k] = $urandom;
    end
    if_req[k] = (rq_if[k] == 1);
    dm_req[k] = (rq_dm[k] == 1);
    rstn[k]   = ($urandom_range(0, 149) != 0);
  endtask

  initial begin
    int lat;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0;
      dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_type[k] = '0;
      dm_addr[k] = '0; dm_wdata[k] = '0;
      act[k] = 0; gcyc[k] = 0; starve[k] = 0; t_if[k] = 0; t_we[k] = 0;
      t_type[k] = '0; t_addr[k] = '0; t_wdata[k] = '0;
      m_if_rd[k] = '0; m_dm_rd[k] = '0; rq_if[k] = 0; rq_dm[k] = 0;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = 32'h1000_0000 + 32'(i);
    end
    #1;
    repeat (3) tick();
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    sample();
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_mem_en", mem_en[0], 1'b0);
    chk("rst_if_rdata", if_rdata[0], 32'd0);
    adv();

    // IF read alone
    if_req[0] = 1'b1; if_addr[0] = 32'h8;
    sample();
    chk("s1_if_gnt", if_gnt[0], 1'b1);
    adv();
    wait_valid(0, 1'b1, 1, lat);
    chk("s1_latency", 32'(lat), 32'd4);
    chk("s1_if_rdata", if_rdata[0], 32'h1000_0002);
    adv();
    if_req[0] = 1'b0;

    // Both request: data first, fetch right after
    if_req[0] = 1'b1; if_addr[0] = 32'hC;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h10; dm_type[0] = 3'b010;
    sample();
    chk("s2_dm_gnt", dm_gnt[0], 1'b1);
    chk("s2_if_gnt_t0", if_gnt[0], 1'b0);
    adv();
    wait_valid(0, 1'b0, 1, lat);
    chk("s2_dm_latency", 32'(lat), 32'd4);
    chk("s2_dm_rdata", dm_rdata[0], 32'h1000_0004);
    adv();
    dm_req[0] = 1'b0;
    sample();
    chk("s2_if_gnt_t5", if_gnt[0], 1'b1);
    adv();
    wait_valid(0, 1'b1, 6, lat);
    chk("s2_if_latency", 32'(lat), 32'd9);
    chk("s2_if_rdata", if_rdata[0], 32'h1000_0003);
    adv();
    if_req[0] = 1'b0;

    // Store, then load back
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h20; dm_wdata[0] = 32'hDEAD_BEEF;
    sample();
    chk("s3_dm_gnt", dm_gnt[0], 1'b1);
    adv();
    sample();
    chk("s3_mem_we", mem_we[0], 1'b1);
    adv();
    wait_valid(0, 1'b0, 2, lat);
    chk("s3_st_latency", 32'(lat), 32'd4);
    chk("s3_dm_rdata_kept", dm_rdata[0], 32'h1000_0004);
    adv();
    dm_we[0] = 1'b0;
    sample();
    chk("s3_ld_gnt", dm_gnt[0], 1'b1);
    adv();
    wait_valid(0, 1'b0, 1, lat);
    chk("s3_ld_rdata", dm_rdata[0], 32'hDEAD_BEEF);
    adv();
    dm_req[0] = 1'b0;

    // Starvation: four data wins, then fetch forced through, then data again
    tick();
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    dm_req[0] = 1'b1; dm_addr[0] = 32'h44;
    for (int g = 0; g < 6; g++) begin
      sample();
      chk($sformatf("s4_if_win%0d", g), if_gnt[0], (g == 4));
      chk($sformatf("s4_dm_win%0d", g), dm_gnt[0], (g != 4));
      adv();
      repeat (W_A + 2) tick();
    end
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    repeat (2) tick();

    // Reset during the second access cycle aborts the fetch
    if_req[0] = 1'b1; if_addr[0] = 32'h4;
    sample();
    chk("s5_if_gnt", if_gnt[0], 1'b1);
    adv();
    tick();
    rstn[0] = 1'b0; if_addr[0] = 32'h14;
    tick();
    rstn[0] = 1'b1;
    sample();
    chk("s5_mem_en", mem_en[0], 1'b0);
    chk("s5_busy", busy[0], 1'b0);
    chk("s5_no_valid", if_valid[0], 1'b0);
    chk("s5_rdata_clr", if_rdata[0], 32'd0);
    chk("s5_regrant", if_gnt[0], 1'b1);
    adv();
    wait_valid(0, 1'b1, 1, lat);
    chk("s5_latency", 32'(lat), 32'd4);
    chk("s5_if_rdata", if_rdata[0], 32'h1000_0005);
    adv();
    if_req[0] = 1'b0;

    // Zero wait states, back-to-back fetches
    if_req[1] = 1'b1; if_addr[1] = 32'h0;
    sample();
    chk("s6_gnt0", if_gnt[1], 1'b1);
    adv();
    wait_valid(1, 1'b1, 1, lat);
    chk("s6_lat0", 32'(lat), 32'd2);
    chk("s6_rdata0", if_rdata[1], 32'h1000_0000);
    adv();
    if_addr[1] = 32'h4;
    sample();
    chk("s6_gnt1", if_gnt[1], 1'b1);
    adv();
    wait_valid(1, 1'b1, 4, lat);
    chk("s6_lat1", 32'(lat), 32'd5);
    chk("s6_rdata1", if_rdata[1], 32'h1000_0001);
    adv();
    if_req[1] = 1'b0;

    // Random traffic on both instances
    repeat (700) begin
      sample();
      adv();
      rand_step(0);
      rand_step(1);
    end

    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b1; if_req[k] = 1'b0; dm_req[k] = 1'b0;
    end
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
